// File: rtl/yadmc_wbm_memtest.sv
// WISHBONE classic-cycle memory exerciser: writes seed-derived pattern over a word range,
// reads it back, and reports the first mismatch or an ack watchdog abort.
module yadmc_wbm_memtest #(
  parameter int                       count_width    = 20,
  parameter int                       timeout_width  = 16,
  parameter logic [timeout_width-1:0] timeout_cycles = 16'd4000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic [31:0]            base_adr,
  input  logic [count_width-1:0] word_count,
  input  logic [31:0]            seed,
  output logic [31:0]            wb_adr_o,
  output logic [31:0]            wb_dat_o,
  input  logic [31:0]            wb_dat_i,
  output logic [3:0]             wb_sel_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  input  logic                   wb_ack_i,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   timeout,
  output logic [31:0]            err_adr,
  output logic [31:0]            err_dat,
  output logic [31:0]            err_exp
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_e;

  localparam logic [count_width-1:0]   IDX_ONE  = count_width'(1);
  localparam logic [timeout_width-1:0] WDT_ONE  = timeout_width'(1);
  localparam logic [timeout_width-1:0] WDT_LAST = timeout_cycles - WDT_ONE;

  state_e                 state_q, state_d;
  logic [count_width-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [31:0]            base_q, base_d, seed_q, seed_d;
  logic [31:0]            adr_q, adr_d, dat_q, dat_d;
  logic [timeout_width-1:0] wdt_q, wdt_d;
  logic                   done_q, done_d, error_q, error_d, timeout_q, timeout_d;
  logic [31:0]            err_adr_q, err_adr_d, err_dat_q, err_dat_d, err_exp_q, err_exp_d;
  logic                   last_beat;

  // Pattern word: seed XOR the zero-extended index with its halves swapped.
  function automatic logic [31:0] pat_f(input logic [31:0] s, input logic [count_width-1:0] idx);
    logic [31:0] iw;
    iw = 32'(idx);
    return s ^ {iw[15:0], iw[31:16]};
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      wdt_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_adr_q <= '0;
      err_dat_q <= '0;
      err_exp_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      wdt_q     <= wdt_d;
      done_q    <= done_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      err_adr_q <= err_adr_d;
      err_dat_q <= err_dat_d;
      err_exp_q <= err_exp_d;
    end
  end

  assign last_beat = (idx_q == cnt_q - IDX_ONE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    seed_d    = seed_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    wdt_d     = wdt_q;
    done_d    = done_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    err_adr_d = err_adr_q;
    err_dat_d = err_dat_q;
    err_exp_d = err_exp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_adr & 32'hFFFF_FFFC;
          seed_d    = seed;
          cnt_d     = word_count;
          idx_d     = '0;
          adr_d     = base_adr & 32'hFFFF_FFFC;
          dat_d     = seed;
          wdt_d     = '0;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          err_adr_d = '0;
          err_dat_d = '0;
          err_exp_d = '0;
          done_d    = (word_count == '0);
          state_d   = (word_count == '0) ? FINISH : WRITE;
        end
      end
      WRITE, READ: begin
        if (wb_ack_i) begin
          wdt_d = '0;
          if (state_q == READ && wb_dat_i != dat_q) begin
            // dat_q holds pat(i) during READ, so it doubles as the expected word.
            error_d   = 1'b1;
            err_adr_d = adr_q;
            err_dat_d = wb_dat_i;
            err_exp_d = dat_q;
            done_d    = 1'b1;
            state_d   = FINISH;
          end else if (last_beat) begin
            idx_d = '0;
            adr_d = base_q;
            dat_d = seed_q;
            if (state_q == WRITE) begin
              state_d = READ;
            end else begin
              done_d  = 1'b1;
              state_d = FINISH;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
            adr_d = adr_q + 32'd4;
            dat_d = pat_f(seed_q, idx_q + IDX_ONE);
          end
        end else if (wdt_q == WDT_LAST) begin
          timeout_d = 1'b1;
          error_d   = 1'b1;
          err_adr_d = adr_q;
          done_d    = 1'b1;
          state_d   = FINISH;
        end else begin
          wdt_d = wdt_q + WDT_ONE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc_o = (state_q == WRITE) || (state_q == READ);
    wb_stb_o = wb_cyc_o;
    wb_we_o  = (state_q == WRITE);
    wb_sel_o = wb_cyc_o ? 4'hF : 4'h0;
    busy     = wb_cyc_o;
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign done     = done_q;
  assign error    = error_q;
  assign timeout  = timeout_q;
  assign err_adr  = err_adr_q;
  assign err_dat  = err_dat_q;
  assign err_exp  = err_exp_q;

endmodule

// File: tb/tb_yadmc_wbm_memtest.sv
// Self-checking bench for yadmc_wbm_memtest: memory responder with optional wait states,
// read corruption and ack suppression, checked against a list-based reference model.
module tb_yadmc_wbm_memtest;
  localparam int CW  = 20;
  localparam int TMO = 4000;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_adr = '0;
  logic [CW-1:0] word_count = '0;
  logic [31:0]   seed = '0;
  logic [31:0]   wb_adr_o, wb_dat_o;
  logic [31:0]   wb_dat_i = '0;
  logic [3:0]    wb_sel_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic          busy, done, error, timeout;
  logic [31:0]   err_adr, err_dat, err_exp;

  yadmc_wbm_memtest dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .base_adr(base_adr),
    .word_count(word_count), .seed(seed), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i), .busy(busy), .done(done), .error(error),
    .timeout(timeout), .err_adr(err_adr), .err_dat(err_dat), .err_exp(err_exp)
  );

  always #5 sys_clk = ~sys_clk;

  // Responder controls
  bit          rdy = 1'b0, junk = 1'b0;
  bit          rand_wait = 1'b0, never_ack = 1'b0, corrupt_en = 1'b0;
  logic [31:0] corrupt_adr = '0;
  logic [31:0] mem [0:1023];

  // A spurious ack while stb is low must be ignored by the master.
  assign wb_ack_i = rdy & (wb_stb_o | junk);

  always @(negedge sys_clk) begin
    rdy  = !never_ack && (!rand_wait || ($urandom_range(0, 2) == 0));
    junk = rand_wait && ($urandom_range(0, 3) == 0);
    if (corrupt_en && wb_adr_o == corrupt_adr) wb_dat_i = 32'h0;
    else                                       wb_dat_i = mem[wb_adr_o[11:2]];
  end

  // Bus monitor: cumulative counters, snapshotted by the stimulus per run.
  logic [31:0] obs_adr[$], obs_dat[$];
  bit          obs_we[$];
  int          busy_cnt = 0, stb_cnt = 0, cyc_cnt = 0, hs_bad = 0, sel_bad = 0;

  always @(posedge sys_clk) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      obs_we.push_back(wb_we_o);
      obs_adr.push_back(wb_adr_o);
      obs_dat.push_back(wb_we_o ? wb_dat_o : wb_dat_i);
      if (wb_we_o) mem[wb_adr_o[11:2]] <= wb_dat_o;
    end
    if (busy)                           busy_cnt <= busy_cnt + 1;
    if (wb_stb_o)                       stb_cnt  <= stb_cnt + 1;
    if (wb_cyc_o)                       cyc_cnt  <= cyc_cnt + 1;
    if (wb_cyc_o != wb_stb_o)           hs_bad   <= hs_bad + 1;
    if (wb_cyc_o && wb_sel_o != 4'hF)   sel_bad  <= sel_bad + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_adr(input logic [31:0] b, input int i);
    return (b & 32'hFFFF_FFFC) + 32'(i) * 32'd4;
  endfunction

  function automatic logic [31:0] m_pat(input logic [31:0] s, input int i);
    logic [31:0] x;
    x = 32'(i);
    return s ^ ((x << 16) | (x >> 16));
  endfunction

  task automatic run_case(input string name, input logic [31:0] base, input int n,
                          input logic [31:0] sd, input bit rw, input bit cen,
                          input logic [31:0] cadr, input bit nack, input bit poke,
                          output int q0);
    int          b0, s0, c0, h0, l0, cycles, nobs, nexp;
    bit          poked, e_err, e_tmo;
    logic [31:0] e_adr[$], e_dat[$];
    bit          e_we[$];
    logic [31:0] e_eadr, e_edat, e_eexp, rd;
    @(negedge sys_clk);
    rand_wait = rw; corrupt_en = cen; corrupt_adr = cadr; never_ack = nack;
    q0 = obs_adr.size(); b0 = busy_cnt; s0 = stb_cnt; c0 = cyc_cnt; h0 = hs_bad; l0 = sel_bad;
    base_adr = base; word_count = CW'(n); seed = sd; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; base_adr = $urandom; seed = $urandom; word_count = CW'($urandom);
    cycles = 0; poked = 1'b0;
    while (!done && cycles < 20000) begin
      @(negedge sys_clk);
      cycles++;
      start = 1'b0;
      if (poke && busy && !poked && cycles >= 3) begin
        start = 1'b1; poked = 1'b1;
      end
    end
    start = 1'b0;
    chk($sformatf("%s.done", name), 32'(done), 32'd1);

    // Reference: full write pass, then reads until the first word that comes back wrong.
    e_err = 1'b0; e_tmo = 1'b0; e_eadr = '0; e_edat = '0; e_eexp = '0;
    if (nack) begin
      e_err = 1'b1; e_tmo = 1'b1; e_eadr = m_adr(base, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        e_we.push_back(1'b1); e_adr.push_back(m_adr(base, i)); e_dat.push_back(m_pat(sd, i));
      end
      for (int i = 0; i < n; i++) begin
        rd = (cen && m_adr(base, i) == cadr) ? 32'h0 : m_pat(sd, i);
        e_we.push_back(1'b0); e_adr.push_back(m_adr(base, i)); e_dat.push_back(rd);
        if (rd != m_pat(sd, i)) begin
          e_err = 1'b1; e_eadr = m_adr(base, i); e_edat = rd; e_eexp = m_pat(sd, i);
          break;
        end
      end
    end
    nobs = obs_adr.size() - q0;
    nexp = e_adr.size();
    chk($sformatf("%s.beats", name), 32'(nobs), 32'(nexp));
    for (int k = 0; k < nobs && k < nexp; k++) begin
      chk($sformatf("%s.we[%0d]", name, k),  32'(obs_we[q0+k]), 32'(e_we[k]));
      chk($sformatf("%s.adr[%0d]", name, k), obs_adr[q0+k], e_adr[k]);
      chk($sformatf("%s.dat[%0d]", name, k), obs_dat[q0+k], e_dat[k]);
    end
    chk($sformatf("%s.error", name),   32'(error),   32'(e_err));
    chk($sformatf("%s.timeout", name), 32'(timeout), 32'(e_tmo));
    chk($sformatf("%s.err_adr", name), err_adr, e_eadr);
    chk($sformatf("%s.err_dat", name), err_dat, e_edat);
    chk($sformatf("%s.err_exp", name), err_exp, e_eexp);
    chk($sformatf("%s.busy", name),    32'(busy),     32'd0);
    chk($sformatf("%s.cyc", name),     32'(wb_cyc_o), 32'd0);
    chk($sformatf("%s.hs", name),      32'(hs_bad - h0),  32'd0);
    chk($sformatf("%s.sel", name),     32'(sel_bad - l0), 32'd0);
    if (!rw && !nack && !e_err) chk($sformatf("%s.busy_cycles", name), 32'(busy_cnt - b0), 32'(2 * n));
    if (nack)   chk($sformatf("%s.stb_cycles", name), 32'(stb_cnt - s0), 32'(TMO));
    if (n == 0) chk($sformatf("%s.no_cyc", name), 32'(cyc_cnt - c0), 32'd0);
    $display("run %s: base=%h n=%0d seed=%h beats=%0d error=%0d timeout=%0d err_adr=%h",
             name, base, n, sd, nobs, error, timeout, err_adr);
    rand_wait = 1'b0; corrupt_en = 1'b0; never_ack = 1'b0;
  endtask

  initial begin
    int q0, n;
    logic [31:0] b, s;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;

    repeat (3) @(negedge sys_clk);
    chk("rst.cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst.stb", 32'(wb_stb_o), 32'd0);
    chk("rst.we",  32'(wb_we_o),  32'd0);
    chk("rst.sel", 32'(wb_sel_o), 32'd0);
    chk("rst.adr", wb_adr_o, 32'd0);
    chk("rst.dat", wb_dat_o, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    chk("rst.err_adr", err_adr, 32'd0);
    sys_rst_n = 1'b1;

    run_case("basic", 32'h100, 4, 32'hA5A5_0000, 0, 0, 32'h0, 0, 0, q0);
    chk("basic.w2_adr", obs_adr[q0+2], 32'h108);
    chk("basic.w2_dat", obs_dat[q0+2], 32'hA5A7_0000);
    chk("basic.w3_dat", obs_dat[q0+3], 32'hA5A6_0000);

    run_case("corrupt", 32'h100, 4, 32'hA5A5_0000, 0, 1, 32'h108, 0, 0, q0);
    chk("corrupt.err_exp_fixed", err_exp, 32'hA5A7_0000);

    run_case("noack", 32'h200, 3, 32'h1234_5678, 0, 0, 32'h0, 1, 0, q0);
    run_case("zero", 32'h300, 0, 32'hCAFE_F00D, 0, 0, 32'h0, 0, 0, q0);
    run_case("wrap", 32'hFFFF_FFF2, 8, 32'h0F0F_1234, 0, 0, 32'h0, 0, 0, q0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(4, 40);
      b = $urandom;
      s = $urandom;
      run_case($sformatf("rand%0d", r), b, n, s, 1, r[0],
               m_adr(b, $urandom_range(0, n - 1)), 0, 1, q0);
    end

    // Reset in the middle of a write pass releases the bus at once.
    @(negedge sys_clk);
    never_ack = 1'b1; base_adr = 32'h340; word_count = CW'(10); seed = 32'h55AA_55AA; start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("midrst.pre_cyc", 32'(wb_cyc_o), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst.cyc",  32'(wb_cyc_o), 32'd0);
    chk("midrst.stb",  32'(wb_stb_o), 32'd0);
    chk("midrst.adr",  wb_adr_o, 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.error", 32'(error), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1; never_ack = 1'b0;

    run_case("after_rst", 32'h400, 6, 32'h0000_FFFF, 0, 0, 32'h0, 0, 0, q0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/yadmc_wbm_memtest.md
Name: yadmc_wbm_memtest

Overview:
- WISHBONE classic-cycle master that drives the yadmc slave port.
- Writes a deterministic pattern over a word range, then reads the range back and compares each word.
- Used for board bring-up and as the in-system exerciser of the cache and SDRAM path: dirty evictions, refills and hits.
- Reports pass/fail, the first failing address and data, and a bus timeout.

Parameters:
- count_width, 20: width of the word-count and index counters.
- timeout_width, 16: width of the ack watchdog counter.
- timeout_cycles, 16'd4000: number of cycles without ack before abort.

Ports:
- sys_clk  in  1  system clock; all logic is on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that starts a run; ignored while busy.
- base_adr  in  32  byte address of the first word; bits [1:0] are ignored and treated as 0.
- word_count  in  count_width  number of 32-bit words to test.
- seed  in  32  pattern seed.
- wb_adr_o  out  32  WISHBONE address.
- wb_dat_o  out  32  WISHBONE write data.
- wb_dat_i  in  32  WISHBONE read data.
- wb_sel_o  out  4  byte selects; always 4'hF during a cycle.
- wb_cyc_o  out  1  WISHBONE cycle.
- wb_stb_o  out  1  WISHBONE strobe.
- wb_we_o  out  1  WISHBONE write enable.
- wb_ack_i  in  1  WISHBONE acknowledge.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- error  out  1  compare mismatch occurred.
- timeout  out  1  watchdog abort occurred.
- err_adr  out  32  byte address of the first failure.
- err_dat  out  32  data read at the first failure.
- err_exp  out  32  expected data at the first failure.

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - state = IDLE.
  - All outputs are 0: wb_* strobes, wb_adr_o, wb_dat_o, wb_sel_o, busy, done, error, timeout, err_*.
- Pattern: word index i runs 0..word_count-1. pat(i) = seed XOR {i zero-extended to 32 bits, rotated left by 16}.
- Address: adr(i) = {base_adr[31:2], 2'b00} + (i << 2), modulo 2^32. Address wrap-around is allowed.
- States: IDLE, WRITE, READ, FINISH.
- IDLE:
  - On start, latch base_adr, word_count and seed; clear done, error, timeout and err_*; set busy = 1.
  - If word_count == 0, go to FINISH with no bus cycle.
  - Otherwise go to WRITE with i = 0.
- WRITE:
  - Drive wb_cyc_o = wb_stb_o = wb_we_o = 1, wb_sel_o = 4'hF, wb_adr_o = adr(i), wb_dat_o = pat(i).
  - On wb_ack_i, i increments at that edge, and the address and data are registered for the next beat.
  - Strobe stays high back-to-back, so the new address is stable from the cycle after ack. This meets the slave's tag lookup, which starts in its idle cycle.
  - Ack on the last index: i = 0, go to READ. wb_we_o drops at the same edge.
- READ:
  - Same as WRITE with wb_we_o = 0.
  - On wb_ack_i, compare wb_dat_i against pat(i) in the ack cycle.
  - On mismatch: latch err_adr, err_dat and err_exp; set error = 1; drop cyc/stb at that edge; go to FINISH.
  - Ack on the last index with a match: go to FINISH.
- FINISH:
  - cyc/stb/we = 0; busy = 0; done = 1.
  - Go to IDLE the next cycle. done, error, timeout and err_* hold until the next accepted start.
- Watchdog:
  - The counter clears on every ack and on entry to WRITE or READ, and increments every cycle while stb is asserted.
  - When it reaches timeout_cycles: drop cyc/stb, set timeout = 1 and error = 1, set err_adr = the current address, go to FINISH.
- Handshake rules:
  - stb is never deasserted before ack, except on watchdog abort.
  - cyc == stb at all times.
  - An ack that arrives while stb = 0 is ignored.
- Concurrent events:
  - start during busy is ignored.
  - start in the same cycle as the FINISH→IDLE transition is ignored; it is accepted only in IDLE.
  - An ack in the same cycle the watchdog expires counts as ack; the watchdog does not fire.
- Reset mid-run: the bus is released immediately (asynchronous) and no status is retained.
- Throughput: with zero-wait acks, one word per cycle. Against yadmc, one word per 2 cycles on a hit.

Test Plan:
- Zero-wait responder: base_adr = 32'h100, word_count = 4, seed = 32'hA5A5_0000.
  - Required writes, in order: (100, A5A5_0000), (104, A5A4_0000), (108, A5A7_0000), (10C, A5A6_0000).
  - Required reads: the same 4 addresses.
  - Required status: done = 1, error = 0; busy high for 8 ack cycles plus overhead.
- Responder corrupts read data at 0x108 to 32'h0.
  - error = 1, err_adr = 32'h108, err_dat = 0, err_exp = 32'hA5A7_0000.
  - No read cycle is issued to 0x10C.
- Responder never acks.
  - After 4000 stb cycles: timeout = 1, error = 1, err_adr = base, cyc = 0.
- word_count = 0.
  - done asserts 2 cycles after start; wb_cyc_o is never asserted.
- Attached to yadmc plus an SDRAM model: base = 0, word_count = 2^14, so the range exceeds the cache and forces dirty evictions and refills.
  - Required: error = 0.
- Two further directed cases:
  - Assert sys_rst_n low mid-WRITE: cyc/stb = 0 in the same cycle; all status = 0.
  - Pulse start while busy: no effect on the run.
